pll_lock_sequencer: RTL and testbench

//  Power-up and recovery sequencer for the system PLL. It runs on the free-running
//  50 MHz reference clock and drives the PLL reset. It waits for a stable lock, then

---
 rtl/pll_lock_sequencer.sv | 144 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer: holds the PLL in reset, waits for a stable lock,
// releases the system reset, and re-resets the PLL with bounded retries on failure.
module pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic       lost_lock,
    output logic [3:0] retry_cnt
);

    localparam int unsigned MaxHs  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                     RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CntMax = (MaxHs > LOCK_TIMEOUT_CYCLES) ? MaxHs : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HoldLast    = CntW'(RST_HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      RetryMax    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      sync_q, sync_d;
    logic [3:0]      retry_q, retry_d;
    logic            lost_q, lost_d;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_rst_q, sys_rst_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;
    logic            locked_s;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        sync_d  = {sync_q[0], pll_locked};

        unique case (state_q)
            StResetPll: begin
                // relock_req is deliberately ignored here so the hold is never stretched
                if (cnt_q == HoldLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (relock_req) begin
                    state_d = StResetPll;
                end else if (locked_s) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    retry_d = (retry_q == RetryMax) ? retry_q : retry_q + 4'd1;
                    state_d = (retry_d == RetryMax) ? StFault : StResetPll;
                end
            end
            StStable: begin
                if (relock_req) begin
                    state_d = StResetPll;
                end else if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    retry_d = '0;
                end
            end
            StRun: begin
                // Lock loss and relock both land in StResetPll; loss also flags lost_lock
                if (!locked_s) begin
                    state_d = StResetPll;
                    lost_d  = 1'b1;
                end else if (relock_req) begin
                    state_d = StResetPll;
                end
            end
            StFault: begin
                if (relock_req) state_d = StResetPll;
            end
            default: state_d = StResetPll;
        endcase

        if (relock_req && (state_q != StResetPll)) retry_d = '0;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end

        // Outputs are registered from the next state so they move on the same edge as it
        pll_rst_d = (state_d == StResetPll) || (state_d == StFault);
        sys_rst_d = (state_d != StRun);
        ready_d   = (state_d == StRun);
        fault_d   = (state_d == StFault);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= StResetPll;
            cnt_q     <= '0;
            sync_q    <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign lost_lock = lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed table, hand-written corner sequences and
// random traffic, all cross-checked against an elapsed-time reference model.
module tb_pll_lock_sequencer;

    localparam int H = 4;
    localparam int S = 8;
    localparam int T = 20;
    localparam int M = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fault, lost_lock;
    logic [3:0] retry_cnt;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES    (H),
        .LOCK_STABLE_CYCLES (S),
        .LOCK_TIMEOUT_CYCLES(T),
        .MAX_RETRIES        (M)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault),
        .lost_lock (lost_lock),
        .retry_cnt (retry_cnt)
    );

    always #5 refclk = ~refclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase plus the edge it was entered on; lock seen through a 2-deep delay
    localparam int MRst = 0, MWait = 1, MStable = 2, MRun = 3, MFault = 4;
    int   m_phase = MRst;
    int   cyc = 0;
    int   since = 0;
    int   m_retry = 0;
    logic m_lost = 1'b0;
    logic h0 = 1'b0, h1 = 1'b0;

    function automatic void model_edge(input logic r, input logic rl, input logic lk);
        logic ls;
        int   n;
        int   nxt;
        cyc++;
        if (r) begin
            m_phase = MRst;
            since   = cyc;
            m_retry = 0;
            m_lost  = 1'b0;
            h0      = 1'b0;
            h1      = 1'b0;
            return;
        end
        ls  = h0;
        h0  = h1;
        h1  = lk;
        n   = cyc - since;
        nxt = m_phase;
        case (m_phase)
            MRst:    if (n == H) nxt = MWait;
            MWait: begin
                if (rl) nxt = MRst;
                else if (ls) nxt = MStable;
                else if (n == T) begin
                    m_retry++;
                    nxt = (m_retry >= M) ? MFault : MRst;
                end
            end
            MStable: begin
                if (rl) nxt = MRst;
                else if (!ls) nxt = MWait;
                else if (n == S) begin
                    nxt     = MRun;
                    m_retry = 0;
                end
            end
            MRun: begin
                if (!ls) begin
                    nxt    = MRst;
                    m_lost = 1'b1;
                end else if (rl) nxt = MRst;
            end
            default: if (rl) nxt = MRst;
        endcase
        if (rl && m_phase != MRst) m_retry = 0;
        if (nxt != m_phase) begin
            m_phase = nxt;
            since   = cyc;
        end
    endfunction

    function automatic logic [8:0] actual();
        return {pll_rst, sys_rst, ready, fault, lost_lock, retry_cnt};
    endfunction

    task automatic compare_model();
        logic [8:0] exp;
        exp = {(m_phase == MRst) || (m_phase == MFault), m_phase != MRun, m_phase == MRun,
               m_phase == MFault, m_lost, 4'(m_retry)};
        vectors++;
        if (actual() !== exp) begin
            miscompares++;
            $display("FAIL model cyc=%0d got {pr,sr,rdy,flt,lost,retry}=%b want %b",
                     cyc, actual(), exp);
        end
    endtask

    task automatic step(input logic r, input logic rl, input logic lk);
        rst        = r;
        relock_req = rl;
        pll_locked = lk;
        @(posedge refclk);
        model_edge(r, rl, lk);
        #1;
        compare_model();
    endtask

    task automatic steps(input logic r, input logic rl, input logic lk, input int n);
        for (int k = 0; k < n; k++) step(r, rl, lk);
    endtask

    task automatic check_exp(input string name, input logic pr, input logic sr, input logic rd,
                             input logic ft, input logic ll, input logic [3:0] rc);
        logic [8:0] exp;
        exp = {pr, sr, rd, ft, ll, rc};
        vectors++;
        if (actual() !== exp) begin
            miscompares++;
            $display("FAIL %s got {pr,sr,rdy,flt,lost,retry}=%b want %b", name, actual(), exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       relock;
        logic       locked;
        int         n;
        logic       pr;
        logic       sr;
        logic       rd;
        logic       ft;
        logic       ll;
        logic [3:0] rc;
    } vec_t;

    vec_t tbl[23];
    logic lk_r;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

        for (int i = 0; i < 23; i++) begin
            steps(tbl[i].rst, tbl[i].relock, tbl[i].locked, tbl[i].n);
            check_exp($sformatf("row%0d", i), tbl[i].pr, tbl[i].sr, tbl[i].rd, tbl[i].ft,
                      tbl[i].ll, tbl[i].rc);
        end

        // rst mid-WAIT_LOCK with one retry recorded, then again in FAULT
        steps(1'b0, 1'b0, 1'b0, T);
        check_exp("t5_retry1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        steps(1'b0, 1'b0, 1'b0, H + 5);
        check_exp("t5_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b0, 1'b0);
        check_exp("t5_rst_wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        steps(1'b0, 1'b0, 1'b0, H);
        check_exp("t5_restart", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        steps(1'b0, 1'b0, 1'b0, T + H + T);
        check_exp("t5_fault", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
        step(1'b1, 1'b0, 1'b0);
        check_exp("t5_rst_fault", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // relock_req during the hold must not extend it
        steps(1'b0, 1'b0, 1'b0, 2);
        step(1'b0, 1'b1, 1'b0);
        check_exp("t6_hold3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0);
        check_exp("t6_hold_end", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        steps(1'b0, 1'b0, 1'b1, S + 3);
        check_exp("t6_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // relock_req on the same edge that sees the lock loss
        steps(1'b0, 1'b0, 1'b0, 2);
        step(1'b0, 1'b1, 1'b0);
        check_exp("t6_coincident", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        steps(1'b0, 1'b0, 1'b0, H - 1);
        check_exp("t6_hold_still", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b0);
        check_exp("t6_hold_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);

        lk_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 14) == 0) lk_r = ~lk_r;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0, lk_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
